// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs els_p input words into one wide output word
// Ready/valid in, valid/yumi out; last_i flushes a partial group early.
module word_packer #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [els_p*width_p-1:0]   data_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  input  logic                       yumi_i
);

  localparam int CW   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CNTW = $clog2(els_p + 1);

  logic                     full_q, full_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [els_p*width_p-1:0] buf_q, buf_d;
  logic [CNTW-1:0]          count_q, count_d;

  logic accept, drain, close;

  assign ready_o = ~full_q | yumi_i;
  assign accept  = valid_i & ready_o;
  assign drain   = yumi_i & full_q;
  assign close   = accept & ((int'(cnt_q) == els_p - 1) | last_i);

  // A drain clears the buffer first so a same-cycle accept lands on a clean word;
  // cnt_q is already 0 whenever full_q is set, so the new word goes to slot 0.
  always_comb begin
    full_d  = full_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    count_d = count_q;
    if (drain) begin
      full_d  = 1'b0;
      buf_d   = '0;
      count_d = '0;
    end
    if (accept) begin
      buf_d[int'(cnt_q)*width_p +: width_p] = data_i;
      if (close) begin
        full_d  = 1'b1;
        count_d = CNTW'(cnt_q) + CNTW'(1);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q  <= 1'b0;
      cnt_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = buf_q;
  assign count_o = count_q;

  a_count_nonzero: assert property (@(posedge clk_i) disable iff (reset_i)
    valid_o |-> (count_o != '0));
  a_cnt_range: assert property (@(posedge clk_i) disable iff (reset_i)
    int'(cnt_q) < els_p);

endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - directed and randomised self-checking bench for word_packer
module tb_word_packer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic [2:0]  count_o;
  logic        yumi_i;
  logic        yumi_drv = 1'b0;
  logic        tie_yumi = 1'b0;

  int tests = 0;
  int fails = 0;

  assign yumi_i = tie_yumi ? valid_o : yumi_drv;

  word_packer #(.width_p(8), .els_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .count_o (count_o),
    .yumi_i  (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic drain_one();
    yumi_drv = 1'b1;
    step();
    yumi_drv = 1'b0;
  endtask

  // Reference model state for the randomised phase
  logic [31:0] exp_data_q[$];
  logic [2:0]  exp_cnt_q[$];
  logic [31:0] cur_w;
  int          cur_n;
  logic [31:0] prev_data;
  logic [2:0]  prev_cnt;
  logic        prev_stall;

  initial begin
    // Reset state
    #2 reset_i = 1'b1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data",  data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ready", ready_o, 1);
    step();
    reset_i = 1'b0;
    step();

    // 1: full group, then backpressure
    send(8'h11, 0);
    chk("t1_v_after1", valid_o, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    chk("t1_valid", valid_o, 1);
    chk("t1_data",  data_o, 32'h44332211);
    chk("t1_count", count_o, 4);
    chk("t1_ready", ready_o, 0);
    valid_i = 1'b1;
    data_i  = 8'h99;
    step();
    step();
    chk("t1_hold_data",  data_o, 32'h44332211);
    chk("t1_hold_count", count_o, 4);
    chk("t1_hold_ready", ready_o, 0);
    valid_i = 1'b0;
    drain_one();
    chk("t1_drained_v", valid_o, 0);
    chk("t1_drained_d", data_o, 0);
    chk("t1_drained_c", count_o, 0);

    // 2: partial group flushed by last_i
    send(8'hAA, 0);
    send(8'hBB, 1);
    chk("t2_valid", valid_o, 1);
    chk("t2_data",  data_o, 32'h0000BBAA);
    chk("t2_count", count_o, 2);
    drain_one();
    send(8'h01, 1);
    chk("t2_slot0_data",  data_o, 32'h00000001);
    chk("t2_slot0_count", count_o, 1);
    drain_one();
    // last_i with valid_i=0 must not close anything
    last_i = 1'b1;
    step();
    last_i = 1'b0;
    chk("t2_last_novalid", valid_o, 0);

    // 3: streaming with yumi tied to valid_o
    tie_yumi = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      #1;
      chk($sformatf("t3_ready_%0d", i), ready_o, 1);
      step();
      if (i == 4) begin
        chk("t3_v4", valid_o, 1);
        chk("t3_d4", data_o, 32'h04030201);
      end
      if (i == 5) chk("t3_v5", valid_o, 0);
      if (i == 8) begin
        chk("t3_v8", valid_o, 1);
        chk("t3_d8", data_o, 32'h08070605);
      end
    end
    valid_i = 1'b0;
    step();
    chk("t3_end_v", valid_o, 0);
    tie_yumi = 1'b0;

    // 4: drain and accept in the same cycle
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    yumi_drv = 1'b1;
    send(8'h55, 0);
    yumi_drv = 1'b0;
    chk("t4_v", valid_o, 0);
    chk("t4_partial", data_o, 32'h00000055);
    send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    chk("t4_data",  data_o, 32'h88776655);
    chk("t4_count", count_o, 4);
    drain_one();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    yumi_drv = 1'b1;
    send(8'h55, 1);
    yumi_drv = 1'b0;
    chk("t4l_valid", valid_o, 1);
    chk("t4l_data",  data_o, 32'h00000055);
    chk("t4l_count", count_o, 1);
    drain_one();

    // 5: async reset mid-group
    send(8'hA1, 0);
    send(8'hA2, 0);
    chk("t5_pre_data", data_o, 32'h0000A2A1);
    #2 reset_i = 1'b1;
    #1;
    chk("t5_rst_valid", valid_o, 0);
    chk("t5_rst_data",  data_o, 0);
    chk("t5_rst_count", count_o, 0);
    chk("t5_rst_ready", ready_o, 1);
    step();
    reset_i = 1'b0;
    send(8'hC1, 0);
    chk("t5_no_stale", data_o, 32'h000000C1);
    send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
    chk("t5_data",  data_o, 32'hC4C3C2C1);
    chk("t5_count", count_o, 4);
    drain_one();

    // 6: random gaps and stalls against a scoreboard
    begin
      int sent = 0;
      int stall = 0;
      int budget = 0;
      logic have = 1'b0;
      cur_w = '0;
      cur_n = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_cnt = '0;
      while ((sent < 1000 || exp_data_q.size() != 0 || cur_n != 0) && budget < 20000) begin
        budget++;
        if (valid_o && prev_stall) begin
          chk("t6_stable_data",  data_o, prev_data);
          chk("t6_stable_count", count_o, prev_cnt);
        end
        if (!have && sent < 1000 && $urandom_range(0, 2) != 0) begin
          have   = 1'b1;
          data_i = 8'(sent);
          last_i = ($urandom_range(0, 7) == 0) || (sent == 999);
        end
        valid_i  = have;
        yumi_drv = valid_o && (stall == 0);
        #1;
        if (yumi_drv) begin
          if (exp_data_q.size() == 0) begin
            chk("t6_unexpected_out", 1, 0);
          end else begin
            chk("t6_data",  data_o,  exp_data_q.pop_front());
            chk("t6_count", count_o, exp_cnt_q.pop_front());
          end
          stall = $urandom_range(0, 5);
        end else if (valid_o) begin
          stall--;
        end
        if (have && ready_o) begin
          cur_w[cur_n*8 +: 8] = data_i;
          cur_n++;
          if (cur_n == 4 || last_i) begin
            exp_data_q.push_back(cur_w);
            exp_cnt_q.push_back(3'(cur_n));
            cur_w = '0;
            cur_n = 0;
          end
          have = 1'b0;
          sent++;
        end
        prev_stall = valid_o && !yumi_drv;
        prev_data  = data_o;
        prev_cnt   = count_o;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
      end
      yumi_drv = 1'b0;
      chk("t6_budget", budget < 20000, 1);
      chk("t6_words_sent", sent, 1000);
      chk("t6_queue_empty", exp_data_q.size(), 0);
      chk("t6_final_valid", valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
